// File: rtl/game_ctrl.sv
// game_ctrl: match controller for a two-player paddle game.
//
// Sequences a match through IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER),
// keeps score, chooses the serve direction and gates paddle move commands.
// Frame-based waits count vblank rising edges.
//
// Ports
//   clk                 pixel clock, all logic on the rising edge
//   rst_n               synchronous active-low reset
//   vblank              vertical-blank level (synchronous to clk)
//   start               start/restart button (synchronous to clk)
//   btn_{l,r}_{up,down} raw paddle buttons (asynchronous)
//   miss_left/right     one-cycle pulses: ball crossed the left/right goal line
//   l_up..r_down        gated paddle move commands
//   ball_reset          one-cycle pulse to re-centre the ball
//   ball_enable         high while the ball may move
//   serve_dir           next serve direction, 0 toward left, 1 toward right
//   score_l, score_r    current scores, saturating at 15
//   state               IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
//   winner              valid in OVER: 0 left, 1 right
module game_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic       start,
  input  logic       btn_l_up,
  input  logic       btn_l_down,
  input  logic       btn_r_up,
  input  logic       btn_r_down,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       l_up,
  output logic       l_down,
  output logic       r_up,
  output logic       r_down,
  output logic       ball_reset,
  output logic       ball_enable,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       winner
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
  localparam logic [7:0] ServeFrames = 8'(SERVE_FRAMES);
  localparam logic [7:0] PointFrames = 8'(POINT_FRAMES);

  // Button vector order: {r_down, r_up, l_down, l_up}
  logic [3:0] btn_raw;
  logic [3:0] btn_meta_q, btn_sync_q;

  logic       vblank_q;
  logic       start_q;
  logic       start_armed_q;
  logic       frame_tick;
  logic       start_edge;
  logic       expire;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic       ball_reset_q, ball_reset_d;
  logic       ball_enable_q, ball_enable_d;
  logic [3:0] cmd_q, cmd_d;
  logic       move_ok;

  assign btn_raw = {btn_r_down, btn_r_up, btn_l_down, btn_l_up};

  assign frame_tick = vblank & ~vblank_q;
  // Armed only once start has been seen low after reset, so a button held
  // through reset cannot launch a match.
  assign start_edge = start & ~start_q & start_armed_q;
  assign expire     = frame_tick && (cnt_q == 8'd1);

  // Edge detectors and button synchronizers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vblank_q      <= 1'b0;
      start_q       <= 1'b0;
      start_armed_q <= 1'b0;
      btn_meta_q    <= 4'b0000;
      btn_sync_q    <= 4'b0000;
    end else begin
      vblank_q      <= vblank;
      start_q       <= start;
      start_armed_q <= start_armed_q | ~start;
      btn_meta_q    <= btn_raw;
      btn_sync_q    <= btn_meta_q;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    ball_reset_d = 1'b0;

    if (frame_tick && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end

    case (state_q)
      StIdle, StOver: begin
        if (start_edge) begin
          state_d      = StServe;
          score_l_d    = 4'd0;
          score_r_d    = 4'd0;
          serve_dir_d  = 1'b1;
          ball_reset_d = 1'b1;
          cnt_d        = ServeFrames;
        end
      end

      StServe: begin
        if (expire) begin
          state_d = StPlay;
        end
      end

      StPlay: begin
        if (miss_left || miss_right) begin
          // A simultaneous double miss is treated as a replayed point.
          if (miss_left && !miss_right) begin
            score_r_d   = (score_r_q == 4'hF) ? score_r_q : score_r_q + 4'd1;
            serve_dir_d = 1'b0;
          end else if (miss_right && !miss_left) begin
            score_l_d   = (score_l_q == 4'hF) ? score_l_q : score_l_q + 4'd1;
            serve_dir_d = 1'b1;
          end
          state_d      = StPoint;
          ball_reset_d = 1'b1;
          cnt_d        = PointFrames;
        end
      end

      StPoint: begin
        if (expire) begin
          if ((score_l_q == WinScore) || (score_r_q == WinScore)) begin
            state_d  = StOver;
            winner_d = (score_l_q == WinScore) ? 1'b0 : 1'b1;
          end else begin
            state_d      = StServe;
            ball_reset_d = 1'b1;
            cnt_d        = ServeFrames;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered against the upcoming state so that enables and
  // paddle gating change on the same edge as the state output.
  always_comb begin
    move_ok       = (state_d == StServe) || (state_d == StPlay);
    ball_enable_d = (state_d == StPlay);
    cmd_d[0]      = btn_sync_q[0] & ~btn_sync_q[1] & move_ok;
    cmd_d[1]      = btn_sync_q[1] & ~btn_sync_q[0] & move_ok;
    cmd_d[2]      = btn_sync_q[2] & ~btn_sync_q[3] & move_ok;
    cmd_d[3]      = btn_sync_q[3] & ~btn_sync_q[2] & move_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      serve_dir_q   <= 1'b1;
      winner_q      <= 1'b0;
      ball_reset_q  <= 1'b0;
      ball_enable_q <= 1'b0;
      cmd_q         <= 4'b0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      ball_reset_q  <= ball_reset_d;
      ball_enable_q <= ball_enable_d;
      cmd_q         <= cmd_d;
    end
  end

  assign l_up        = cmd_q[0];
  assign l_down      = cmd_q[1];
  assign r_up        = cmd_q[2];
  assign r_down      = cmd_q[3];
  assign ball_reset  = ball_reset_q;
  assign ball_enable = ball_enable_q;
  assign serve_dir   = serve_dir_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign state       = state_q;
  assign winner      = winner_q;

endmodule
